fetch_sequencer: RTL and testbench

- Sequences the processor's combinational instruction memory: holds the program counter, drives the memory read address, and captures the returned byte into an instruction register.
- Presents that register to decode with a valid/ready handshake.
- Handles start, stall, branch redirect with flush, end-of-program detection, external halt, and out-of-range branch error.
- Sits between instruction memory and the decode/control unit.

---
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the fetch sequencer: instruction memory port, decode
// handshake, control requests and status flags.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              halt_req;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_instr;
  logic [7:0]        ir_out;
  logic [ADDR_W-1:0] pc_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, halt_req, branch_valid, branch_target, imem_instr, ir_ready,
    output imem_addr, ir_out, pc_out, ir_valid, busy, done, err
  );

  modport slave (
    output start, halt_req, branch_valid, branch_target, imem_instr, ir_ready,
    input  imem_addr, ir_out, pc_out, ir_valid, busy, done, err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and instruction register in front of a combinational
// instruction memory, with stall, branch/flush, drain and halt handling.
module fetch_sequencer #(
  parameter int                  ADDR_W   = 8,
  parameter int                  PROG_LEN = 25,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        irOut_q, irOut_d;
  logic [ADDR_W-1:0] pcOut_q, pcOut_d;
  logic              irValid_q, irValid_d;
  logic              err_q, err_d;
  logic              launch_q, launch_d;

  logic slotFree;
  logic targetOk;

  assign slotFree = !irValid_q || bus.ir_ready;
  assign targetOk = {1'b0, bus.branch_target} < PROG_END;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      irOut_q   <= '0;
      pcOut_q   <= '0;
      irValid_q <= 1'b0;
      err_q     <= 1'b0;
      launch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      irOut_q   <= irOut_d;
      pcOut_q   <= pcOut_d;
      irValid_q <= irValid_d;
      err_q     <= err_d;
      launch_q  <= launch_d;
    end
  end

  // The first FETCH cycle after start only presents the start address, so the
  // first instruction lands two edges after start.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    irOut_d   = irOut_q;
    pcOut_d   = pcOut_q;
    irValid_d = irValid_q;
    err_d     = err_q;
    launch_d  = 1'b0;

    case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d  = FETCH;
          pc_d     = RESET_PC;
          err_d    = 1'b0;
          launch_d = 1'b1;
        end
      end

      FETCH: begin
        if (bus.halt_req) begin
          state_d = DRAIN;
          if (bus.ir_ready) irValid_d = 1'b0;
        end else if (bus.branch_valid) begin
          irValid_d = 1'b0;
          if (targetOk) begin
            pc_d = bus.branch_target;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else if (!launch_q && slotFree) begin
          irOut_d   = bus.imem_instr;
          pcOut_d   = pc_q;
          irValid_d = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
          if (pc_q == LAST_PC) state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (slotFree) begin
          irValid_d = 1'b0;
          state_d   = HALT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.ir_out    = irOut_q;
  assign bus.pc_out    = pcOut_q;
  assign bus.ir_valid  = irValid_q;
  assign bus.busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.done      = (state_q == HALT);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer against a memory holding addr+0x10.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  fetch_sequencer_if #(.ADDR_W(8)) bus ();

  fetch_sequencer #(
    .ADDR_W   (8),
    .PROG_LEN (25),
    .RESET_PC (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_instr = (bus.imem_addr < 8'd25) ? (bus.imem_addr + 8'h10) : 8'hFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic hr, input logic bv,
                               input logic [7:0] bt, input logic rdy);
    bus.start         = st;
    bus.halt_req      = hr;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
    bus.ir_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIr(input string tag, input logic [7:0] ir, input logic [7:0] pc);
    checkOutput({tag, "_valid"}, 32'(bus.ir_valid), 32'd1);
    checkOutput({tag, "_ir"}, 32'(bus.ir_out), 32'(ir));
    checkOutput({tag, "_pc"}, 32'(bus.pc_out), 32'(pc));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    checkOutput({tag, "_ir_out"}, 32'(bus.ir_out), 32'd0);
    checkOutput({tag, "_pc_out"}, 32'(bus.pc_out), 32'd0);
    checkOutput({tag, "_ir_valid"}, 32'(bus.ir_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checkResetState("reset");

    $display("[TB] full program run");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("run_busy", 32'(bus.busy), 32'd1);
    checkOutput("run_lat1_valid", 32'(bus.ir_valid), 32'd0);
    tick();
    checkOutput("run_lat2_valid", 32'(bus.ir_valid), 32'd0);
    tick();
    checkIr("run_first", 8'h10, 8'd0);
    for (int i = 1; i < 25; i++) begin
      tick();
      checkIr("run_seq", 8'(8'h10 + i), 8'(i));
    end
    tick();
    checkOutput("run_end_done", 32'(bus.done), 32'd1);
    checkOutput("run_end_busy", 32'(bus.busy), 32'd0);
    checkOutput("run_end_valid", 32'(bus.ir_valid), 32'd0);
    checkOutput("run_end_addr", 32'(bus.imem_addr), 32'd25);

    $display("[TB] stall");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("restart_done", 32'(bus.done), 32'd0);
    tick();
    tick();
    checkIr("restart_first", 8'h10, 8'd0);
    tick();
    tick();
    tick();
    checkIr("pre_stall", 8'h13, 8'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIr("stall_hold", 8'h13, 8'd3);
      checkOutput("stall_addr", 32'(bus.imem_addr), 32'd4);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkIr("stall_release", 8'h14, 8'd4);

    $display("[TB] branch");
    tick();
    checkIr("pre_branch", 8'h15, 8'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("branch_bubble", 32'(bus.ir_valid), 32'd0);
    checkOutput("branch_addr", 32'(bus.imem_addr), 32'd2);
    tick();
    checkIr("branch_target", 8'h12, 8'd2);

    $display("[TB] bad branch");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("badbr_err", 32'(bus.err), 32'd1);
    checkOutput("badbr_done", 32'(bus.done), 32'd1);
    checkOutput("badbr_valid", 32'(bus.ir_valid), 32'd0);
    checkOutput("badbr_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("badbr_err_clr", 32'(bus.err), 32'd0);
    checkOutput("badbr_done_clr", 32'(bus.done), 32'd0);
    tick();
    tick();
    checkIr("badbr_refetch", 8'h10, 8'd0);

    $display("[TB] halt during stall");
    for (int i = 0; i < 7; i++) tick();
    checkIr("pre_halt", 8'h17, 8'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkIr("halt_stall", 8'h17, 8'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIr("halt_drain", 8'h17, 8'd7);
    checkOutput("halt_drain_addr", 32'(bus.imem_addr), 32'd8);
    checkOutput("halt_drain_busy", 32'(bus.busy), 32'd1);
    checkOutput("halt_drain_done", 32'(bus.done), 32'd0);
    tick();
    checkIr("halt_drain_hold", 8'h17, 8'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("halt_done", 32'(bus.done), 32'd1);
    checkOutput("halt_valid", 32'(bus.ir_valid), 32'd0);
    checkOutput("halt_addr", 32'(bus.imem_addr), 32'd8);
    tick();
    checkOutput("halt_still_done", 32'(bus.done), 32'd1);
    checkOutput("halt_no_fetch", 32'(bus.imem_addr), 32'd8);

    $display("[TB] reset mid-fetch");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 9; i++) tick();
    checkIr("pre_reset", 8'h18, 8'd8);
    checkOutput("pre_reset_addr", 32'(bus.imem_addr), 32'd9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkResetState("midreset");
    tick();
    checkOutput("midreset_idle", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkIr("midreset_resume", 8'h10, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
